// File: rtl/block_dispatcher.sv
// Block distributor: walks a 3-D grid x-fastest and issues blocks to multiprocessors
// round-robin, caps resident blocks per MP and signals kernel completion once all retire.
module block_dispatcher #(
    parameter int NUM_MPS        = 8,
    parameter int GRID_DIM_WIDTH = 10,
    parameter int MAX_RES_BLOCKS = 2,
    parameter int MPID_DEPTH     = $clog2(NUM_MPS),
    parameter int RES_WIDTH      = $clog2(MAX_RES_BLOCKS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        launch,
    input  logic [3*GRID_DIM_WIDTH-1:0] grid_dim,
    input  logic [NUM_MPS-1:0]          mp_ready,
    input  logic [NUM_MPS-1:0]          blk_done,
    output logic                        start,
    output logic [MPID_DEPTH-1:0]       mpid,
    output logic [3*GRID_DIM_WIDTH-1:0] bidx,
    output logic                        busy,
    output logic                        kernel_done,
    output logic                        err
);

    localparam int unsigned NMPS = NUM_MPS;
    localparam int          GW   = GRID_DIM_WIDTH;

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t                 state_q;
    logic [GW-1:0]          gx_q, gy_q, gz_q;
    logic [GW-1:0]          x_q, y_q, z_q;
    logic [GW-1:0]          x_d, y_d, z_d;
    logic [MPID_DEPTH-1:0]  rr_ptr_q;
    logic [RES_WIDTH-1:0]   res_q [NUM_MPS];
    logic [RES_WIDTH-1:0]   res_d [NUM_MPS];
    logic                   start_q, kernel_done_q, err_q, err_d;
    logic [MPID_DEPTH-1:0]  mpid_q;
    logic [3*GW-1:0]        bidx_q;

    logic [NUM_MPS-1:0]     eligible;
    logic                   grant_vld;
    logic [MPID_DEPTH-1:0]  grant_id;
    logic                   res_err, all_idle;
    logic                   launch_acc, zero_dim;
    logic                   last_x, last_y, last_z, last_blk;

    function automatic logic [MPID_DEPTH-1:0] wrap_add(input logic [MPID_DEPTH-1:0] base,
                                                        input int unsigned off);
        return MPID_DEPTH'((32'(base) + off) % NMPS);
    endfunction

    assign launch_acc = (state_q == IDLE) && launch;
    assign zero_dim   = (grid_dim[GW-1:0] == '0) || (grid_dim[2*GW-1:GW] == '0) ||
                        (grid_dim[3*GW-1:2*GW] == '0);
    assign last_x     = (x_q == gx_q - 1'b1);
    assign last_y     = (y_q == gy_q - 1'b1);
    assign last_z     = (z_q == gz_q - 1'b1);
    assign last_blk   = last_x && last_y && last_z;

    // Search starts at rr_ptr and takes the first eligible MP in wrap-around order.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int unsigned i = 0; i < NMPS; i++) begin
            eligible[i] = mp_ready[i] && (res_q[i] < RES_WIDTH'(MAX_RES_BLOCKS));
        end
        for (int unsigned k = 0; k < NMPS; k++) begin
            if ((state_q == DISPATCH) && !grant_vld && eligible[wrap_add(rr_ptr_q, k)]) begin
                grant_vld = 1'b1;
                grant_id  = wrap_add(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        if (launch_acc) begin
            x_d = '0;
            y_d = '0;
            z_d = '0;
        end else if (grant_vld) begin
            if (!last_x) begin
                x_d = x_q + 1'b1;
            end else begin
                x_d = '0;
                if (!last_y) begin
                    y_d = y_q + 1'b1;
                end else begin
                    y_d = '0;
                    z_d = z_q + 1'b1;
                end
            end
        end
    end

    // A grant and a completion on the same MP cancel; a completion on an empty MP is an error.
    always_comb begin
        res_err  = 1'b0;
        all_idle = 1'b1;
        for (int unsigned i = 0; i < NMPS; i++) begin
            res_d[i] = res_q[i];
            if (res_q[i] != '0) all_idle = 1'b0;
            if (grant_vld && (grant_id == MPID_DEPTH'(i)) && !blk_done[i]) begin
                res_d[i] = res_q[i] + 1'b1;
            end else if (!(grant_vld && (grant_id == MPID_DEPTH'(i))) && blk_done[i]) begin
                if (res_q[i] == '0) res_err = 1'b1;
                else                res_d[i] = res_q[i] - 1'b1;
            end
        end
        err_d = (launch_acc ? 1'b0 : err_q) | res_err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            gx_q          <= '0;
            gy_q          <= '0;
            gz_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            z_q           <= '0;
            rr_ptr_q      <= '0;
            start_q       <= 1'b0;
            mpid_q        <= '0;
            bidx_q        <= '0;
            kernel_done_q <= 1'b0;
            err_q         <= 1'b0;
            for (int unsigned i = 0; i < NMPS; i++) res_q[i] <= '0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            z_q           <= z_d;
            err_q         <= err_d;
            start_q       <= grant_vld;
            kernel_done_q <= (state_q == DONE);
            for (int unsigned i = 0; i < NMPS; i++) res_q[i] <= res_d[i];
            if (grant_vld) begin
                mpid_q   <= grant_id;
                bidx_q   <= {z_q, y_q, x_q};
                rr_ptr_q <= wrap_add(grant_id, 1);
            end
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        gx_q    <= grid_dim[GW-1:0];
                        gy_q    <= grid_dim[2*GW-1:GW];
                        gz_q    <= grid_dim[3*GW-1:2*GW];
                        state_q <= zero_dim ? DONE : DISPATCH;
                    end
                end
                DISPATCH: if (grant_vld && last_blk) state_q <= DRAIN;
                DRAIN:    if (all_idle) state_q <= DONE;
                DONE:     state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    assign start       = start_q;
    assign mpid        = mpid_q;
    assign bidx        = bidx_q;
    assign busy        = (state_q != IDLE);
    assign kernel_done = kernel_done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_block_dispatcher.sv
// Scoreboard bench for block_dispatcher: expected issues are queued as stimulus is driven
// and popped as start pulses appear.
module tb_block_dispatcher;

    localparam int NM = 4;
    localparam int GW = 4;
    localparam int MR = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              launch = 1'b0;
    logic [3*GW-1:0]   grid_dim = '0;
    logic [NM-1:0]     mp_ready = '0;
    logic [NM-1:0]     blk_done = '0;
    logic              start;
    logic [1:0]        mpid;
    logic [3*GW-1:0]   bidx;
    logic              busy, kernel_done, err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]      mpid;
        logic [3*GW-1:0] bidx;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    block_dispatcher #(
        .NUM_MPS(NM),
        .GRID_DIM_WIDTH(GW),
        .MAX_RES_BLOCKS(MR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .launch(launch),
        .grid_dim(grid_dim),
        .mp_ready(mp_ready),
        .blk_done(blk_done),
        .start(start),
        .mpid(mpid),
        .bidx(bidx),
        .busy(busy),
        .kernel_done(kernel_done),
        .err(err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && start) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("mpid", 32'(mpid), 32'(e.mpid));
                check("bidx", 32'(bidx), 32'(e.bidx));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int m, input int z, input int y, input int x);
        exp_t e;
        e.mpid = 2'(m);
        e.bidx = {4'(z), 4'(y), 4'(x)};
        sb.push_back(e);
    endtask

    task automatic pulse_done(input logic [NM-1:0] v);
        blk_done = v;
        tick();
        blk_done = '0;
    endtask

    task automatic do_launch(input logic [3*GW-1:0] g);
        grid_dim = g;
        launch   = 1'b1;
        tick();
        launch   = 1'b0;
    endtask

    task automatic wait_kdone(input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick();
            if (kernel_done) begin
                seen = 1'b1;
                check("kdone_busy", 32'(busy), 32'd0);
            end
        end
        check("kdone_seen", 32'(seen), 32'd1);
        tick();
        check("kdone_pulse", 32'(kernel_done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kd_cnt;
        bit seen;

        // Reset state
        tick();
        tick();
        check("rst_start", 32'(start), 32'd0);
        check("rst_mpid", 32'(mpid), 32'd0);
        check("rst_bidx", 32'(bidx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_kdone", 32'(kernel_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        tick();

        // 1: grid {1,1,3}, all ready
        mp_ready = 4'b1111;
        push(0, 0, 0, 0);
        push(1, 0, 0, 1);
        push(2, 0, 0, 2);
        do_launch({4'd1, 4'd1, 4'd3});
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_nostart", 32'(start), 32'd0);
        tick();
        check("t1_start_lat", 32'(start), 32'd1);
        repeat (4) tick();
        check("t1_sb", 32'(sb.size()), 32'd0);
        check("t1_drain_busy", 32'(busy), 32'd1);
        pulse_done(4'b0111);
        wait_kdone(10);
        check("t1_err", 32'(err), 32'd0);

        // 2: grid {1,2,2}, only MP3 ready; residency cap stalls issue
        mp_ready = 4'b1000;
        push(3, 0, 0, 0);
        push(3, 0, 0, 1);
        do_launch({4'd1, 4'd2, 4'd2});
        repeat (6) tick();
        check("t2_stall_sb", 32'(sb.size()), 32'd0);
        check("t2_stall_busy", 32'(busy), 32'd1);
        push(3, 0, 1, 0);
        pulse_done(4'b1000);
        repeat (4) tick();
        check("t2_third", 32'(sb.size()), 32'd0);
        push(3, 0, 1, 1);
        pulse_done(4'b1000);
        repeat (4) tick();
        check("t2_fourth", 32'(sb.size()), 32'd0);
        pulse_done(4'b1000);
        pulse_done(4'b1000);
        wait_kdone(10);

        // 3: zero-dimension grid {0,5,5}
        mp_ready = 4'b1111;
        do_launch({4'd0, 4'd5, 4'd5});
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_kd_early", 32'(kernel_done), 32'd0);
        tick();
        check("t3_busy_off", 32'(busy), 32'd0);
        check("t3_kdone", 32'(kernel_done), 32'd1);
        check("t3_start", 32'(start), 32'd0);
        tick();
        check("t3_kd_pulse", 32'(kernel_done), 32'd0);

        // 4: grant and completion coincide on MP1; completion on empty MP2
        mp_ready = 4'b0010;
        push(1, 0, 0, 0);
        push(1, 0, 0, 1);
        push(1, 0, 0, 2);
        do_launch({4'd1, 4'd1, 4'd4});
        tick();
        pulse_done(4'b0110);
        check("t4_err", 32'(err), 32'd1);
        repeat (5) tick();
        check("t4_cnt_kept", 32'(sb.size()), 32'd0);
        check("t4_err_sticky", 32'(err), 32'd1);
        push(1, 0, 0, 3);
        pulse_done(4'b0010);
        repeat (3) tick();
        check("t4_last", 32'(sb.size()), 32'd0);
        pulse_done(4'b0010);
        pulse_done(4'b0010);
        wait_kdone(10);
        check("t4_err_end", 32'(err), 32'd1);

        // 5: launch during DISPATCH ignored, then reset mid-kernel
        mp_ready = 4'b0001;
        push(0, 0, 0, 0);
        push(0, 0, 0, 1);
        do_launch({4'd1, 4'd1, 4'd6});
        check("t5_err_clr", 32'(err), 32'd0);
        repeat (5) tick();
        check("t5_stall", 32'(sb.size()), 32'd0);
        do_launch({4'd1, 4'd1, 4'd2});
        check("t5_busy", 32'(busy), 32'd1);
        push(0, 0, 0, 2);
        pulse_done(4'b0001);
        repeat (4) tick();
        check("t5_grid_kept", 32'(sb.size()), 32'd0);
        rst = 1'b0;
        #1;
        check("t5_rst_start", 32'(start), 32'd0);
        check("t5_rst_mpid", 32'(mpid), 32'd0);
        check("t5_rst_bidx", 32'(bidx), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_err", 32'(err), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        kd_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (kernel_done) kd_cnt++;
        end
        check("t5_no_kdone", 32'(kd_cnt), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);

        // 6: grid {1,1,8}, all ready, immediate retirement
        mp_ready = 4'b1111;
        for (int i = 0; i < 8; i++) push(i % 4, 0, 0, i);
        grid_dim = {4'd1, 4'd1, 4'd8};
        launch   = 1'b1;
        tick();
        launch   = 1'b0;
        seen     = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            blk_done = start ? (4'b0001 << mpid) : 4'b0000;
            if (kernel_done) seen = 1'b1;
        end
        blk_done = '0;
        check("t6_kdone", 32'(seen), 32'd1);
        check("t6_sb", 32'(sb.size()), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        push(0, 0, 0, 0);
        do_launch({4'd1, 4'd1, 4'd1});
        repeat (3) tick();
        check("t6_rr_wrap", 32'(sb.size()), 32'd0);
        pulse_done(4'b0001);
        wait_kdone(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
